// File: rtl/sram_seq_ctrl.sv
// Splits each 32-bit load/store into two 16-bit SRAM phases with WAIT cycles each, freezing the pipeline meanwhile.
// Optional SRAM_RANGE_CHECK_EN: out-of-window accesses keep their timing but suppress WE and read back 0.
module sram_seq_ctrl #(
  parameter int unsigned WAIT = 2,
  parameter int unsigned BASE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_EN,
  output logic        SRAM_LB_EN,
  output logic        SRAM_CE_EN,
  output logic        SRAM_WE_EN,
  output logic        SRAM_OE_EN
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic               oor_q, oor_d;
  logic [16:0]        word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic [17:0]        addr_q, addr_d;

  logic [16:0]        word_c;
  logic               oor_c;
  logic [15:0]        rd_half_c;

  // Halfword-pair index relative to BASE; upper bits drop so the window wraps.
  assign word_c = 17'((address - 32'(BASE)) >> 2);

`ifdef SRAM_RANGE_CHECK_EN
  assign oor_c = (address < 32'(BASE)) || ((address - 32'(BASE)) >= 32'h0008_0000);
`else
  assign oor_c = 1'b0;
`endif

  assign rd_half_c = oor_q ? 16'h0000 : SRAM_DQ;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    oor_d   = oor_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          state_d = LO;
          cnt_d   = '0;
          op_wr_d = wr_en;
          oor_d   = oor_c;
          word_d  = word_c;
          wdata_d = write_data;
        end
      end
      LO: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[15:0] = rd_half_c;
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[31:16] = rd_half_c;
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are decoded from the next state so they leave the flops glitch-free.
  always_comb begin
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = 16'h0000;
    addr_d   = 18'h00000;
    if (state_d == LO || state_d == HI) begin
      addr_d = {word_d, state_d == HI};
      if (op_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
        we_n_d   = (cnt_d == CNT_LAST) || oor_d;
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      oor_q    <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      oor_q    <= oor_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
      addr_q   <= addr_d;
    end
  end

  // ready must fall in the request cycle itself, so it stays combinational.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = ~(wr_en | rd_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign read_data  = rdata_q;
  assign SRAM_DQ    = dq_oe_q ? dq_out_q : 16'bz;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WE_EN = we_n_q;
  assign SRAM_OE_EN = oe_n_q;
  assign SRAM_UB_EN = 1'b0;
  assign SRAM_LB_EN = 1'b0;
  assign SRAM_CE_EN = 1'b0;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Directed vector bench for sram_seq_ctrl with a behavioural 16-bit SRAM on the bus.
module tb_sram_seq_ctrl;

  localparam int unsigned W = 2;

`ifdef SRAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  tri   [15:0] dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, we_n, oe_n;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur_vec = -1;
  int cur_cyc = 0;

  always #5 clk = ~clk;

  sram_seq_ctrl #(.WAIT(W), .BASE(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_UB_EN (ub_n),
    .SRAM_LB_EN (lb_n),
    .SRAM_CE_EN (ce_n),
    .SRAM_WE_EN (we_n),
    .SRAM_OE_EN (oe_n)
  );

  // Behavioural asynchronous SRAM: write on WE low at the clock, read while OE low.
  logic [15:0] mem [0:262143];
  assign dq = (!oe_n && we_n) ? mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!we_n) mem[sram_addr] <= dq;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_addr;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic        we_act;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d cyc=%0d: got %h expected %h", nm, cur_vec, cur_cyc, act, exp);
    end
  endtask

  task automatic chk_idle_pins(input string nm);
    chk({nm, "_we"},   {31'd0, we_n}, 32'd1);
    chk({nm, "_oe"},   {31'd0, oe_n}, 32'd1);
    chk({nm, "_addr"}, {14'd0, sram_addr}, 32'd0);
    chk({nm, "_dq"},   {16'd0, dq}, {16'd0, 16'bz});
  endtask

  // Entered just after a rising edge with the DUT in IDLE; returns at the DONE negedge.
  task automatic do_access(input vec_t v);
    logic        hi;
    int unsigned ph;
    wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
    cur_cyc = 0;
    @(negedge clk);
    chk("c0_ready", {31'd0, ready}, 32'd0);
    chk_idle_pins("c0");
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      cur_cyc = c;
      hi = (c > W);
      ph = (c - 1) % W;
      chk("ph_ready", {31'd0, ready}, 32'd0);
      chk("ph_addr", {14'd0, sram_addr}, {14'd0, v.exp_addr | 18'(hi)});
      if (v.wr) begin
        chk("wr_we", {31'd0, we_n}, (v.we_act && ph != W - 1) ? 32'd0 : 32'd1);
        chk("wr_oe", {31'd0, oe_n}, 32'd1);
        chk("wr_dq", {16'd0, dq}, {16'd0, hi ? v.exp_hi : v.exp_lo});
      end else begin
        chk("rd_we", {31'd0, we_n}, 32'd1);
        chk("rd_oe", {31'd0, oe_n}, 32'd0);
      end
    end
    @(negedge clk);
    cur_cyc = 2 * W + 1;
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_rdata", read_data, v.exp_rd);
    chk_idle_pins("done");
  endtask

  initial begin
    vec[0] = '{1'b1, 1'b0, 32'd1024,      32'hDEADBEEF, 18'h00000, 16'hBEEF, 16'hDEAD, 1'b1, 32'h00000000};
    vec[1] = '{1'b0, 1'b1, 32'd1024,      32'h0,        18'h00000, 16'h0,    16'h0,    1'b0, 32'hDEADBEEF};
    vec[2] = '{1'b1, 1'b1, 32'd1028,      32'h12345678, 18'h00002, 16'h5678, 16'h1234, 1'b1, 32'hDEADBEEF};
    vec[3] = '{1'b0, 1'b1, 32'd1028,      32'h0,        18'h00002, 16'h0,    16'h0,    1'b0, 32'h12345678};
    vec[4] = '{1'b1, 1'b0, 32'h000803FC,  32'hCAFEF00D, 18'h3FFFE, 16'hF00D, 16'hCAFE, 1'b1, 32'h12345678};
    vec[5] = '{1'b0, 1'b1, 32'h000803FC,  32'h0,        18'h3FFFE, 16'h0,    16'h0,    1'b0, 32'hCAFEF00D};
    vec[6] = '{1'b1, 1'b0, 32'd512,       32'hA5A55A5A, 18'h3FF00, 16'h5A5A, 16'hA5A5, !RC,  32'hCAFEF00D};
    vec[7] = '{1'b1, 1'b0, 32'h00080400,  32'h11112222, 18'h00000, 16'h2222, 16'h1111, !RC,  32'hCAFEF00D};
    vec[8] = '{1'b0, 1'b1, 32'd1024,      32'h0,        18'h00000, 16'h0,    16'h0,    1'b0,
               RC ? 32'hDEADBEEF : 32'h11112222};
    vec[9] = '{1'b0, 1'b1, 32'd512,       32'h0,        18'h3FF00, 16'h0,    16'h0,    1'b0,
               RC ? 32'h00000000 : 32'hA5A55A5A};

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_ties", {29'd0, ub_n, lb_n, ce_n}, 32'd0);
    chk_idle_pins("rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      cur_vec = i;
      do_access(vec[i]);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      cur_cyc = -1;
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_rdata", read_data, vec[i].exp_rd);
      chk_idle_pins("idle");
      @(posedge clk); #1;
    end

    // Back-to-back loads with enables held through DONE: one IDLE bubble with ready low.
    cur_vec = 100;
    do_access('{1'b0, 1'b1, 32'd1028, 32'h0, 18'h00002, 16'h0, 16'h0, 1'b0, 32'h12345678});
    @(posedge clk); #1;
    cur_vec = 101;
    do_access('{1'b0, 1'b1, 32'h000803FC, 32'h0, 18'h3FFFE, 16'h0, 16'h0, 1'b0, 32'hCAFEF00D});
    @(posedge clk); #1;
    rd_en = 1'b0;

    // Reset during the HI phase of a load.
    cur_vec = 200;
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1024;
    for (int c = 0; c <= W + 1; c++) @(negedge clk);
    chk("pre_rst_oe", {31'd0, oe_n}, 32'd0);
    chk("pre_rst_addr", {14'd0, sram_addr}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_rdata", read_data, 32'd0);
    chk_idle_pins("mid_rst");
    rd_en = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk_idle_pins("post_rst");
    cur_vec = 201;
    do_access('{1'b0, 1'b1, 32'd1028, 32'h0, 18'h00002, 16'h0, 16'h0, 1'b0, 32'h12345678});
    @(posedge clk); #1;
    rd_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
